iob_cache_write_channel_axi_mo: RTL and testbench

// Write-back line writer for the cache back-end with multiple outstanding AXI4 write bursts.

---
 rtl/iob_cache_write_channel_axi_mo.sv | 189 ++++++++++++++++++
 tb/tb_iob_cache_write_channel_axi_mo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_write_channel_axi_mo.sv
// Write-back line writer: buffers evicted lines and issues overlapping AXI4 write bursts,
// retiring B in order and retrying failed lines. Optional strobes: IOB_CACHE_WR_STRB_EN.
module iob_cache_write_channel_axi_mo #(
   parameter  int ADDR_W          = 32,
   parameter  int FE_DATA_W       = 32,
   parameter  int BE_ADDR_W       = 32,
   parameter  int BE_DATA_W       = 64,
   parameter  int WORD_OFFSET_W   = 3,
   parameter  int AXI_ID_W        = 1,
   parameter  int AXI_ID          = 0,
   parameter  int AXI_LEN_W       = 8,
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int MAX_RETRY       = 3,
   localparam int LINE_W          = FE_DATA_W * (2 ** WORD_OFFSET_W),
   localparam int LOFF            = $clog2(FE_DATA_W / 8) + WORD_OFFSET_W
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   input  logic                   valid_i,
   input  logic [ADDR_W-LOFF-1:0] addr_i,
   input  logic [LINE_W-1:0]      wdata_i,
`ifdef IOB_CACHE_WR_STRB_EN
   input  logic [LINE_W/8-1:0]    wstrb_i,
`endif
   output logic                   ready_o,
   output logic                   idle_o,
   output logic                   err_o,
   output logic [AXI_ID_W-1:0]    axi_awid_o,
   output logic [BE_ADDR_W-1:0]   axi_awaddr_o,
   output logic [AXI_LEN_W-1:0]   axi_awlen_o,
   output logic [2:0]             axi_awsize_o,
   output logic [1:0]             axi_awburst_o,
   output logic                   axi_awlock_o,
   output logic [3:0]             axi_awcache_o,
   output logic [2:0]             axi_awprot_o,
   output logic [3:0]             axi_awqos_o,
   output logic                   axi_awvalid_o,
   input  logic                   axi_awready_i,
   output logic [BE_DATA_W-1:0]   axi_wdata_o,
   output logic [BE_DATA_W/8-1:0] axi_wstrb_o,
   output logic                   axi_wlast_o,
   output logic                   axi_wvalid_o,
   input  logic                   axi_wready_i,
   input  logic [AXI_ID_W-1:0]    axi_bid_i,
   input  logic [1:0]             axi_bresp_i,
   input  logic                   axi_bvalid_i,
   output logic                   axi_bready_o
);

   localparam int BEATS  = LINE_W / BE_DATA_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int RTRY_W = $clog2(MAX_RETRY + 1);
   localparam int LA_W   = ADDR_W - LOFF;
   localparam logic [PTR_W:0] PTR_ONE = 1;

   typedef enum logic {S_RUN, S_DRAIN} state_t;

   state_t              r_state;
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0]      r_wr_ptr, r_aw_ptr, r_w_ptr, r_b_ptr;
   logic [BEAT_W-1:0]   r_beat;
   logic [PTR_W:0]      r_inflight;
   logic [RTRY_W-1:0]   r_retry;
   logic                r_err;
   logic                r_aw_hold;

   logic [LA_W-1:0]     r_addr_mem [MAX_OUTSTANDING];
   logic [LINE_W-1:0]   r_data_mem [MAX_OUTSTANDING];
`ifdef IOB_CACHE_WR_STRB_EN
   logic [LINE_W/8-1:0] r_strb_mem [MAX_OUTSTANDING];
`endif

   logic [PTR_W:0]      w_count;
   logic [PTR_W-1:0]    w_wr_idx, w_aw_idx, w_w_idx;
   logic                w_accept, w_awvalid, w_aw_fire;
   logic                w_wvalid, w_w_fire, w_w_last, w_w_done;
   logic                w_bready, w_b_fire, w_drain_done;
   logic [ADDR_W-1:0]   w_aw_byte_addr;
   logic                w_unused;

   assign w_count  = r_wr_ptr - r_b_ptr;
   assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
   assign w_aw_idx = r_aw_ptr[PTR_W-1:0];
   assign w_w_idx  = r_w_ptr[PTR_W-1:0];

   assign ready_o  = (w_count != (PTR_W+1)'(MAX_OUTSTANDING));
   assign idle_o   = (w_count == '0);
   assign err_o    = r_err;
   assign w_accept = valid_i & ready_o;

   // A request already presented when DRAIN starts stays up until accepted.
   assign w_awvalid    = ((r_state == S_RUN) && (r_aw_ptr != r_wr_ptr)) || r_aw_hold;
   assign w_aw_fire    = w_awvalid & axi_awready_i;
   assign w_wvalid     = (r_w_ptr != r_aw_ptr);
   assign w_w_fire     = w_wvalid & axi_wready_i;
   assign w_w_last     = (r_beat == BEAT_W'(BEATS - 1));
   assign w_w_done     = w_w_fire & w_w_last;
   assign w_bready     = (r_inflight != '0);
   assign w_b_fire     = w_bready & axi_bvalid_i;
   assign w_drain_done = (r_state == S_DRAIN) && !w_bready && !w_wvalid && !w_awvalid;

   assign w_aw_byte_addr = {r_addr_mem[w_aw_idx], {LOFF{1'b0}}};
   assign axi_awid_o     = AXI_ID_W'(AXI_ID);
   assign axi_awaddr_o   = BE_ADDR_W'(w_aw_byte_addr);
   assign axi_awlen_o    = AXI_LEN_W'(BEATS - 1);
   assign axi_awsize_o   = 3'($clog2(BE_DATA_W / 8));
   assign axi_awburst_o  = (BEATS > 1) ? 2'b01 : 2'b00;
   assign axi_awlock_o   = 1'b0;
   assign axi_awcache_o  = 4'b0011;
   assign axi_awprot_o   = 3'b000;
   assign axi_awqos_o    = 4'b0000;
   assign axi_awvalid_o  = w_awvalid;

   assign axi_wdata_o  = r_data_mem[w_w_idx][int'(r_beat)*BE_DATA_W +: BE_DATA_W];
`ifdef IOB_CACHE_WR_STRB_EN
   assign axi_wstrb_o  = r_strb_mem[w_w_idx][int'(r_beat)*(BE_DATA_W/8) +: BE_DATA_W/8];
`else
   assign axi_wstrb_o  = '1;
`endif
   assign axi_wlast_o  = w_w_last;
   assign axi_wvalid_o = w_wvalid;
   assign axi_bready_o = w_bready;

   assign w_unused = ^{axi_bid_i, axi_bresp_i[0]};

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_addr_mem[w_wr_idx] <= addr_i;
         r_data_mem[w_wr_idx] <= wdata_i;
`ifdef IOB_CACHE_WR_STRB_EN
         r_strb_mem[w_wr_idx] <= wstrb_i;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state    <= S_RUN;
         r_wr_ptr   <= '0;
         r_aw_ptr   <= '0;
         r_w_ptr    <= '0;
         r_b_ptr    <= '0;
         r_beat     <= '0;
         r_inflight <= '0;
         r_retry    <= '0;
         r_err      <= 1'b0;
         r_aw_hold  <= 1'b0;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         r_aw_hold <= w_awvalid & ~axi_awready_i;
         if (w_aw_fire) r_aw_ptr <= r_aw_ptr + PTR_ONE;
         if (w_w_fire) r_beat <= w_w_last ? '0 : r_beat + BEAT_W'(1);
         if (w_w_done) r_w_ptr <= r_w_ptr + PTR_ONE;
         r_inflight <= r_inflight + (PTR_W+1)'(w_w_done) - (PTR_W+1)'(w_b_fire);
         case (r_state)
            S_RUN: begin
               if (w_b_fire) begin
                  if (!axi_bresp_i[1]) begin
                     r_b_ptr <= r_b_ptr + PTR_ONE;
                     r_retry <= '0;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // Bus is quiet: replay from the head, or give up on it and replay the rest.
               if (w_drain_done) begin
                  r_state <= S_RUN;
                  if (r_retry < RTRY_W'(MAX_RETRY)) begin
                     r_retry  <= r_retry + RTRY_W'(1);
                     r_aw_ptr <= r_b_ptr;
                     r_w_ptr  <= r_b_ptr;
                  end else begin
                     r_retry  <= '0;
                     r_err    <= 1'b1;
                     r_b_ptr  <= r_b_ptr + PTR_ONE;
                     r_aw_ptr <= r_b_ptr + PTR_ONE;
                     r_w_ptr  <= r_b_ptr + PTR_ONE;
                  end
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_cache_write_channel_axi_mo.sv
// Scoreboard bench for iob_cache_write_channel_axi_mo: AXI slave model with stall,
// error and reset scenarios; expected AW/W traffic is queued when lines are driven.
module tb_iob_cache_write_channel_axi_mo;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } wexp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid_i = 1'b0;
   logic [26:0]  addr_i = '0;
   logic [255:0] wdata_i = '0;
`ifdef IOB_CACHE_WR_STRB_EN
   logic [31:0]  wstrb_i = '1;
`endif
   logic         ready_o, idle_o, err_o;
   logic [0:0]   axi_awid;
   logic [31:0]  axi_awaddr;
   logic [7:0]   axi_awlen;
   logic [2:0]   axi_awsize, axi_awprot;
   logic [1:0]   axi_awburst;
   logic         axi_awlock, axi_awvalid;
   logic [3:0]   axi_awcache, axi_awqos;
   logic         axi_awready = 1'b0;
   logic [63:0]  axi_wdata;
   logic [7:0]   axi_wstrb;
   logic         axi_wlast, axi_wvalid;
   logic         axi_wready = 1'b0;
   logic [0:0]   axi_bid = 1'b0;
   logic [1:0]   axi_bresp = 2'b00;
   logic         axi_bvalid = 1'b0;
   logic         axi_bready;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_aw_q[$];
   wexp_t       exp_w_q[$];
   logic [1:0]  b_resp_q[$];

   bit   aw_stall = 1'b0, w_toggle = 1'b0, arm_ready_ok = 1'b0;
   int   aw_cnt = 0, w_beats = 0, b_cnt = 0, pending_b = 0;
   bit   b_fire = 1'b0, prev_aw_pend = 1'b0, prev_w_pend = 1'b0;
   logic [1:0]  b_last_resp = 2'b00;
   logic [31:0] prev_awaddr = '0;
   logic [72:0] prev_w = '0;

   always #5 clk = ~clk;

   iob_cache_write_channel_axi_mo dut (
      .clk_i(clk), .arst_n_i(rst_n),
      .valid_i(valid_i), .addr_i(addr_i), .wdata_i(wdata_i),
`ifdef IOB_CACHE_WR_STRB_EN
      .wstrb_i(wstrb_i),
`endif
      .ready_o(ready_o), .idle_o(idle_o), .err_o(err_o),
      .axi_awid_o(axi_awid), .axi_awaddr_o(axi_awaddr), .axi_awlen_o(axi_awlen),
      .axi_awsize_o(axi_awsize), .axi_awburst_o(axi_awburst), .axi_awlock_o(axi_awlock),
      .axi_awcache_o(axi_awcache), .axi_awprot_o(axi_awprot), .axi_awqos_o(axi_awqos),
      .axi_awvalid_o(axi_awvalid), .axi_awready_i(axi_awready),
      .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wlast_o(axi_wlast),
      .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready),
      .axi_bid_i(axi_bid), .axi_bresp_i(axi_bresp), .axi_bvalid_i(axi_bvalid),
      .axi_bready_o(axi_bready)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] line_data(input logic [7:0] base);
      logic [255:0] d;
      for (int i = 0; i < 32; i++) d[i*8 +: 8] = base + 8'(i);
      return d;
   endfunction

   task automatic push_exp(input logic [31:0] baddr, input logic [255:0] d, input logic [31:0] s);
      exp_aw_q.push_back(baddr);
      for (int b = 0; b < 4; b++) begin
         wexp_t e;
         e.data = d[b*64 +: 64];
`ifdef IOB_CACHE_WR_STRB_EN
         e.strb = s[b*8 +: 8];
`else
         e.strb = 8'hFF | {8{^s & 1'b0}};
`endif
         e.last = (b == 3);
         exp_w_q.push_back(e);
      end
   endtask

   // Called at a negedge; holds valid until the line is taken.
   task automatic send_line(input logic [31:0] baddr, input logic [255:0] d, input logic [31:0] s);
      int n;
      n = 0;
      valid_i = 1'b1;
      addr_i  = baddr[31:5];
      wdata_i = d;
`ifdef IOB_CACHE_WR_STRB_EN
      wstrb_i = s;
`endif
      while (!ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_val("accept", ready_o, 1'b1);
      if (ready_o) begin
         push_exp(baddr, d, s);
         $display("[TB] REQ addr=%08h", baddr);
      end
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!(idle_o && exp_aw_q.size() == 0 && exp_w_q.size() == 0 && pending_b == 0 && !axi_bvalid)
             && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, {idle_o, 31'(exp_aw_q.size() + exp_w_q.size())}, {1'b1, 31'd0});
   endtask

   // AXI slave model: drives inputs at the negedge and records the handshakes that
   // will take place at the following posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
         pending_b = 0; b_fire = 1'b0; prev_aw_pend = 1'b0; prev_w_pend = 1'b0;
      end else begin
         if (b_fire) begin
            axi_bvalid = 1'b0;
            if (arm_ready_ok && b_last_resp == 2'b00) begin
               check_val("ready_on_first_ok", ready_o, 1'b1);
               arm_ready_ok = 1'b0;
            end
         end
         if (!axi_bvalid && pending_b > 0) begin
            axi_bvalid = 1'b1;
            axi_bresp  = (b_resp_q.size() != 0) ? b_resp_q.pop_front() : 2'b00;
            pending_b--;
         end
         b_fire = axi_bvalid && axi_bready;
         if (b_fire) begin
            b_cnt++;
            b_last_resp = axi_bresp;
            $display("[TB] B resp=%0d", axi_bresp);
         end

         axi_awready = !aw_stall;
         if (prev_aw_pend)
            check_val("aw_stable", {axi_awvalid, axi_awaddr}, {1'b1, prev_awaddr});
         if (axi_awvalid && axi_awready) begin
            if (exp_aw_q.size() == 0) check_val("aw_unexpected", axi_awaddr, 32'hDEAD_0000);
            else check_val("awaddr", axi_awaddr, exp_aw_q.pop_front());
            check_val("aw_len_size_burst", {axi_awlen, axi_awsize, axi_awburst}, {8'd3, 3'd3, 2'b01});
            check_val("aw_attr", {axi_awid, axi_awlock, axi_awcache, axi_awprot, axi_awqos},
                      {1'b0, 1'b0, 4'b0011, 3'b000, 4'b0000});
            aw_cnt++;
            $display("[TB] AW addr=%08h", axi_awaddr);
         end
         prev_aw_pend = axi_awvalid && !axi_awready;
         prev_awaddr  = axi_awaddr;

         axi_wready = w_toggle ? !axi_wready : 1'b1;
         if (prev_w_pend)
            check_val("w_stable", {axi_wvalid, axi_wdata, axi_wstrb, axi_wlast}, {1'b1, prev_w});
         if (axi_wvalid && axi_wready) begin
            if (exp_w_q.size() == 0) begin
               check_val("w_unexpected", axi_wdata, 64'hDEAD_0000);
            end else begin
               wexp_t e;
               e = exp_w_q.pop_front();
               check_val("wbeat", {axi_wdata, axi_wstrb, axi_wlast}, {e.data, e.strb, e.last});
            end
            w_beats++;
            if (axi_wlast) begin
               pending_b++;
               $display("[TB] W burst done data3=%016h", axi_wdata);
            end
         end
         prev_w_pend = axi_wvalid && !axi_wready;
         prev_w      = {axi_wdata, axi_wstrb, axi_wlast};
      end
   end

   initial begin
      int aw0, b0, wb0, n;

      repeat (3) @(negedge clk);
      check_val("rst_ready_idle_err", {ready_o, idle_o, err_o}, 3'b110);
      check_val("rst_valids", {axi_awvalid, axi_wvalid, axi_bready}, 3'b000);
      rst_n = 1'b1;
      @(negedge clk);

      // single line
      send_line(32'h0000_1000, line_data(8'h00), 32'hFFFF_FFFF);
      wait_idle("t1_idle");

      // fill the buffer with AW stalled
      aw_stall = 1'b1;
      aw0 = aw_cnt;
      for (int i = 0; i < 4; i++)
         send_line(32'h0000_2000 + 32'(i) * 32'h20, line_data(8'h10 * 8'(i)), '1);
      check_val("t2_full_ready", ready_o, 1'b0);
      fork
         send_line(32'h0000_2080, line_data(8'h40), '1);
         begin
            repeat (3) @(negedge clk);
            check_val("t2_still_full", ready_o, 1'b0);
            check_val("t2_no_aw", aw_cnt - aw0, 0);
            arm_ready_ok = 1'b1;
            aw_stall = 1'b0;
         end
      join
      wait_idle("t2_idle");
      check_val("t2_ok_seen", arm_ready_ok, 1'b0);
      check_val("t2_aw_count", aw_cnt - aw0, 5);

      // W backpressure
      w_toggle = 1'b1;
      wb0 = w_beats;
      send_line(32'h0000_3000, line_data(8'h80), '1);
      send_line(32'h0000_3020, line_data(8'hA0), '1);
      wait_idle("t3_idle");
      check_val("t3_beats", w_beats - wb0, 8);
      w_toggle = 1'b0;

      // SLVERR on the second of three lines
      aw0 = aw_cnt; b0 = b_cnt;
      b_resp_q.push_back(2'b00);
      b_resp_q.push_back(2'b10);
      send_line(32'h0000_4000, line_data(8'h11), '1);
      send_line(32'h0000_4020, line_data(8'h22), '1);
      send_line(32'h0000_4040, line_data(8'h33), '1);
      push_exp(32'h0000_4020, line_data(8'h22), '1);
      push_exp(32'h0000_4040, line_data(8'h33), '1);
      wait_idle("t4_idle");
      check_val("t4_err", err_o, 1'b0);
      check_val("t4_aw_count", aw_cnt - aw0, 5);
      check_val("t4_b_count", b_cnt - b0, 5);

      // persistent error: four attempts then drop
      aw0 = aw_cnt;
      for (int i = 0; i < 4; i++) b_resp_q.push_back(2'b10);
      send_line(32'h0000_6000, line_data(8'h55), '1);
      for (int i = 0; i < 3; i++) push_exp(32'h0000_6000, line_data(8'h55), '1);
      wait_idle("t5_idle");
      check_val("t5_err_set", err_o, 1'b1);
      check_val("t5_attempts", aw_cnt - aw0, 4);
      send_line(32'h0000_6020, line_data(8'h66), '1);
      wait_idle("t5_next_idle");
      check_val("t5_err_sticky", err_o, 1'b1);

`ifdef IOB_CACHE_WR_STRB_EN
      send_line(32'h0000_7000, line_data(8'h77), 32'h0000_00F0);
      wait_idle("t6_strb_idle");
`endif

      // reset in the middle of a burst
      wb0 = w_beats; aw0 = aw_cnt; n = 0;
      send_line(32'h0000_5000, line_data(8'h90), '1);
      while (aw_cnt == aw0 && n < 100) begin @(negedge clk); n++; end
      aw_stall = 1'b1;
      send_line(32'h0000_5020, line_data(8'hB0), '1);
      while (w_beats < wb0 + 2 && n < 200) begin @(negedge clk); n++; end
      check_val("t7_pre_rst_valids", {axi_awvalid, axi_wvalid}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check_val("t7_rst_valids", {axi_awvalid, axi_wvalid, axi_bready}, 3'b000);
      check_val("t7_rst_ready_idle_err", {ready_o, idle_o, err_o}, 3'b110);
      repeat (2) @(negedge clk);
      exp_aw_q.delete();
      exp_w_q.delete();
      b_resp_q.delete();
      aw_stall = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      send_line(32'h0000_8000, line_data(8'hC0), '1);
      wait_idle("t7_recover_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
